axi_read_arbiter: RTL and testbench

AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

---
 rtl/axi_read_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_axi_read_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_arbiter.sv
// AXI read-address/read-data arbiter: two masters, two 64 KiB slave regions
// plus an internal default slave that answers unmapped reads with DECERR.
// One transaction is in flight at a time; grant/route drive external muxes.
module axi_read_arbiter #(
  parameter int unsigned       ADDR_W  = 32,
  parameter int unsigned       LEN_W   = 4,
  parameter logic [ADDR_W-1:0] S0_BASE = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] S1_BASE = 32'h0001_0000
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  // master read-address channels
  input  logic              ARVALID_M0,
  input  logic              ARVALID_M1,
  input  logic [ADDR_W-1:0] ARADDR_M0,
  input  logic [ADDR_W-1:0] ARADDR_M1,
  input  logic [LEN_W-1:0]  ARLEN_M0,
  input  logic [LEN_W-1:0]  ARLEN_M1,
  output logic              ARREADY_M0,
  output logic              ARREADY_M1,
  // slave read-address channels
  output logic              ARVALID_S0,
  output logic              ARVALID_S1,
  input  logic              ARREADY_S0,
  input  logic              ARREADY_S1,
  // slave read-data status
  input  logic              RVALID_S0,
  input  logic              RVALID_S1,
  input  logic              RLAST_S0,
  input  logic              RLAST_S1,
  output logic              RREADY_S0,
  output logic              RREADY_S1,
  // master read-data handshake
  output logic              RVALID_M0,
  output logic              RVALID_M1,
  input  logic              RREADY_M0,
  input  logic              RREADY_M1,
  // mux controls and default-slave response fields
  output logic [1:0]        grant,
  output logic [1:0]        route,
  output logic [1:0]        def_rresp,
  output logic              def_rlast
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DEF  = 2'd3
  } state_t;

  localparam logic [1:0] ROUTE_S0  = 2'd0;
  localparam logic [1:0] ROUTE_S1  = 2'd1;
  localparam logic [1:0] ROUTE_DEF = 2'd2;

  state_t            state, state_nxt;
  logic [1:0]        grant_q;
  logic [1:0]        route_q;
  logic [LEN_W-1:0]  cnt_q;
  logic              last_m1_q;   // 1: M1 was the most recent grantee

  // per-index views of the paired ports
  logic [1:0]        arvalid_m, arready_s, rvalid_s, rlast_s, rready_m;
  logic [1:0]        arready_m, arvalid_s, rready_s, rvalid_m;
  logic [ADDR_W-1:0] araddr_m [2];
  logic [LEN_W-1:0]  arlen_m  [2];

  logic              own;         // index of granted master
  logic              tgt;         // index of routed slave (route 0/1)
  logic              is_def;
  logic              pick;
  logic [1:0]        route_dec;
  logic              addr_hs, data_last, def_last;
  logic              unused_addr_low;

  assign arvalid_m   = {ARVALID_M1, ARVALID_M0};
  assign arready_s   = {ARREADY_S1, ARREADY_S0};
  assign rvalid_s    = {RVALID_S1,  RVALID_S0};
  assign rlast_s     = {RLAST_S1,   RLAST_S0};
  assign rready_m    = {RREADY_M1,  RREADY_M0};
  assign araddr_m[0] = ARADDR_M0;
  assign araddr_m[1] = ARADDR_M1;
  assign arlen_m[0]  = ARLEN_M0;
  assign arlen_m[1]  = ARLEN_M1;

  // Only the 64 KiB page number takes part in decode.
  assign unused_addr_low = ^{ARADDR_M0[15:0], ARADDR_M1[15:0]};

  assign {ARREADY_M1, ARREADY_M0} = arready_m;
  assign {ARVALID_S1, ARVALID_S0} = arvalid_s;
  assign {RREADY_S1,  RREADY_S0}  = rready_s;
  assign {RVALID_M1,  RVALID_M0}  = rvalid_m;
  assign grant = grant_q;
  assign route = route_q;

  assign own    = grant_q[1];
  assign tgt    = route_q[0];
  assign is_def = (route_q == ROUTE_DEF);

  assign addr_hs   = arvalid_m[own] & arready_s[tgt];
  assign data_last = rvalid_s[tgt] & rready_m[own] & rlast_s[tgt];
  assign def_last  = rready_m[own] & (cnt_q == '0);

  // Round-robin pick and address decode of the winning master.
  always_comb begin
    if (arvalid_m == 2'b11) begin
      pick = ~last_m1_q;
    end else begin
      pick = arvalid_m[1];
    end
    route_dec = ROUTE_DEF;
    if (araddr_m[pick][ADDR_W-1:16] == S0_BASE[ADDR_W-1:16]) begin
      route_dec = ROUTE_S0;
    end else if (araddr_m[pick][ADDR_W-1:16] == S1_BASE[ADDR_W-1:16]) begin
      route_dec = ROUTE_S1;
    end
  end

  // State register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant/route capture, round-robin history and default-slave beat counter.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      grant_q   <= 2'b00;
      route_q   <= ROUTE_S0;
      cnt_q     <= '0;
      last_m1_q <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (|arvalid_m) begin
            grant_q   <= pick ? 2'b10 : 2'b01;
            route_q   <= route_dec;
            last_m1_q <= pick;
          end
        end
        ADDR: begin
          if (is_def) begin
            cnt_q <= arlen_m[own];
          end
        end
        DEF: begin
          if (rready_m[own] && (cnt_q != '0)) begin
            cnt_q <= cnt_q - LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (|arvalid_m) state_nxt = ADDR;
      ADDR: begin
        if (is_def) begin
          state_nxt = DEF;
        end else if (addr_hs) begin
          state_nxt = DATA;
        end
      end
      DATA: if (data_last) state_nxt = IDLE;
      DEF:  if (def_last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake steering toward the granted master and routed slave.
  always_comb begin
    arready_m = '0;
    arvalid_s = '0;
    rready_s  = '0;
    rvalid_m  = '0;
    def_rresp = 2'b00;
    def_rlast = 1'b0;
    case (state)
      ADDR: begin
        if (is_def) begin
          arready_m[own] = 1'b1;
        end else begin
          arvalid_s[tgt] = arvalid_m[own];
          arready_m[own] = arready_s[tgt];
        end
      end
      DATA: begin
        if (!is_def) begin
          rvalid_m[own] = rvalid_s[tgt];
          rready_s[tgt] = rready_m[own];
        end
      end
      DEF: begin
        rvalid_m[own] = 1'b1;
        def_rresp     = 2'b11;
        def_rlast     = (cnt_q == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Testbench for axi_read_arbiter: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a transaction model.
module tb_axi_read_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  arv, arrdy_s, rv_s, rl_s, rr_m;
  logic [31:0] addr [2];
  logic [3:0]  len  [2];

  logic        arready_m0, arready_m1, arvalid_s0, arvalid_s1;
  logic        rready_s0, rready_s1, rvalid_m0, rvalid_m1;
  logic [1:0]  grant, route, def_rresp;
  logic        def_rlast;
  logic [14:0] outs;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axi_read_arbiter #(
    .ADDR_W (32),
    .LEN_W  (4),
    .S0_BASE(32'h0000_0000),
    .S1_BASE(32'h0001_0000)
  ) dut (
    .ACLK      (clk),
    .ARESETn   (rst_n),
    .ARVALID_M0(arv[0]),
    .ARVALID_M1(arv[1]),
    .ARADDR_M0 (addr[0]),
    .ARADDR_M1 (addr[1]),
    .ARLEN_M0  (len[0]),
    .ARLEN_M1  (len[1]),
    .ARREADY_M0(arready_m0),
    .ARREADY_M1(arready_m1),
    .ARVALID_S0(arvalid_s0),
    .ARVALID_S1(arvalid_s1),
    .ARREADY_S0(arrdy_s[0]),
    .ARREADY_S1(arrdy_s[1]),
    .RVALID_S0 (rv_s[0]),
    .RVALID_S1 (rv_s[1]),
    .RLAST_S0  (rl_s[0]),
    .RLAST_S1  (rl_s[1]),
    .RREADY_S0 (rready_s0),
    .RREADY_S1 (rready_s1),
    .RVALID_M0 (rvalid_m0),
    .RVALID_M1 (rvalid_m1),
    .RREADY_M0 (rr_m[0]),
    .RREADY_M1 (rr_m[1]),
    .grant     (grant),
    .route     (route),
    .def_rresp (def_rresp),
    .def_rlast (def_rlast)
  );

  assign outs = {arready_m1, arready_m0, arvalid_s1, arvalid_s0,
                 rready_s1, rready_s0, rvalid_m1, rvalid_m0,
                 grant, route, def_rresp, def_rlast};

  typedef struct {
    logic [1:0]  arv;
    logic [31:0] a0, a1;
    logic [3:0]  l0, l1;
    logic [1:0]  ars, rv, rl, rr;
    logic [14:0] exp;
  } vec_t;

  vec_t tbl [18];

  function automatic logic [14:0] mk(input logic [1:0] arr, input logic [1:0] avs,
                                     input logic [1:0] rrs, input logic [1:0] rvm,
                                     input logic [1:0] gr, input logic [1:0] rt,
                                     input logic [1:0] rsp, input logic lst);
    return {arr, avs, rrs, rvm, gr, rt, rsp, lst};
  endfunction

  function automatic vec_t mkrow(input logic [1:0] a, input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [3:0] l0, input logic [3:0] l1, input logic [1:0] ars,
                                 input logic [1:0] rv, input logic [1:0] rl, input logic [1:0] rr,
                                 input logic [14:0] e);
    vec_t v;
    v.arv = a; v.a0 = a0; v.a1 = a1; v.l0 = l0; v.l1 = l1;
    v.ars = ars; v.rv = rv; v.rl = rl; v.rr = rr; v.exp = e;
    return v;
  endfunction

  function automatic int region(input logic [31:0] a);
    int page;
    page = int'(a >> 16);
    if (page == 0) return 0;
    if (page == 1) return 1;
    return 2;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clr();
    arv = '0; arrdy_s = '0; rv_s = '0; rl_s = '0; rr_m = '0;
    addr[0] = '0; addr[1] = '0; len[0] = '0; len[1] = '0;
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    clr();
    #1;
    chk({nm, " reset outs"}, {1'b0, outs}, 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // transaction-level reference state
  bit         busy, in_addr;
  int         owner, tgt, left, prev;
  logic [1:0] m_grant, m_route;
  logic [1:0] e_arr, e_avs, e_rrs, e_rvm, e_rsp;
  logic       e_lst;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clr();
    rst_n = 1'b1;

    // ---------------- directed table: S0 burst then default-slave burst
    tbl[0]  = mkrow(2'b01, 32'h10, 32'h0, 4'd3, 4'd0, 2'b00, 2'b00, 2'b00, 2'b00, mk(2'b00,2'b00,2'b00,2'b00,2'b00,2'd0,2'b00,1'b0));
    tbl[1]  = mkrow(2'b01, 32'h10, 32'h0, 4'd3, 4'd0, 2'b01, 2'b00, 2'b00, 2'b00, mk(2'b01,2'b01,2'b00,2'b00,2'b01,2'd0,2'b00,1'b0));
    tbl[2]  = mkrow(2'b00, 32'h0,  32'h0, 4'd0, 4'd0, 2'b00, 2'b01, 2'b00, 2'b01, mk(2'b00,2'b00,2'b01,2'b01,2'b01,2'd0,2'b00,1'b0));
    tbl[3]  = mkrow(2'b00, 32'h0,  32'h0, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00, 2'b01, mk(2'b00,2'b00,2'b01,2'b00,2'b01,2'd0,2'b00,1'b0));
    tbl[4]  = mkrow(2'b00, 32'h0,  32'h0, 4'd0, 4'd0, 2'b00, 2'b01, 2'b00, 2'b01, mk(2'b00,2'b00,2'b01,2'b01,2'b01,2'd0,2'b00,1'b0));
    tbl[5]  = mkrow(2'b00, 32'h0,  32'h0, 4'd0, 4'd0, 2'b00, 2'b01, 2'b00, 2'b00, mk(2'b00,2'b00,2'b00,2'b01,2'b01,2'd0,2'b00,1'b0));
    tbl[6]  = mkrow(2'b00, 32'h0,  32'h0, 4'd0, 4'd0, 2'b00, 2'b01, 2'b00, 2'b01, mk(2'b00,2'b00,2'b01,2'b01,2'b01,2'd0,2'b00,1'b0));
    tbl[7]  = mkrow(2'b00, 32'h0,  32'h0, 4'd0, 4'd0, 2'b00, 2'b01, 2'b01, 2'b01, mk(2'b00,2'b00,2'b01,2'b01,2'b01,2'd0,2'b00,1'b0));
    tbl[8]  = mkrow(2'b00, 32'h0,  32'h0, 4'd0, 4'd0, 2'b00, 2'b01, 2'b00, 2'b01, mk(2'b00,2'b00,2'b00,2'b00,2'b01,2'd0,2'b00,1'b0));
    tbl[9]  = mkrow(2'b01, 32'h0005_0000, 32'h0, 4'd2, 4'd0, 2'b00, 2'b00, 2'b00, 2'b00, mk(2'b00,2'b00,2'b00,2'b00,2'b01,2'd0,2'b00,1'b0));
    tbl[10] = mkrow(2'b01, 32'h0005_0000, 32'h0, 4'd2, 4'd0, 2'b01, 2'b00, 2'b00, 2'b00, mk(2'b01,2'b00,2'b00,2'b00,2'b01,2'd2,2'b00,1'b0));
    tbl[11] = mkrow(2'b10, 32'h0, 32'h0001_0000, 4'd0, 4'd0, 2'b00, 2'b01, 2'b00, 2'b00, mk(2'b00,2'b00,2'b00,2'b01,2'b01,2'd2,2'b11,1'b0));
    tbl[12] = mkrow(2'b10, 32'h0, 32'h0001_0000, 4'd0, 4'd0, 2'b00, 2'b01, 2'b00, 2'b01, mk(2'b00,2'b00,2'b00,2'b01,2'b01,2'd2,2'b11,1'b0));
    tbl[13] = mkrow(2'b10, 32'h0, 32'h0001_0000, 4'd0, 4'd0, 2'b00, 2'b01, 2'b00, 2'b00, mk(2'b00,2'b00,2'b00,2'b01,2'b01,2'd2,2'b11,1'b0));
    tbl[14] = mkrow(2'b10, 32'h0, 32'h0001_0000, 4'd0, 4'd0, 2'b00, 2'b01, 2'b00, 2'b01, mk(2'b00,2'b00,2'b00,2'b01,2'b01,2'd2,2'b11,1'b0));
    tbl[15] = mkrow(2'b10, 32'h0, 32'h0001_0000, 4'd0, 4'd0, 2'b00, 2'b01, 2'b00, 2'b00, mk(2'b00,2'b00,2'b00,2'b01,2'b01,2'd2,2'b11,1'b1));
    tbl[16] = mkrow(2'b10, 32'h0, 32'h0001_0000, 4'd0, 4'd0, 2'b00, 2'b01, 2'b00, 2'b01, mk(2'b00,2'b00,2'b00,2'b01,2'b01,2'd2,2'b11,1'b1));
    tbl[17] = mkrow(2'b10, 32'h0, 32'h0001_0000, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00, 2'b00, mk(2'b00,2'b00,2'b00,2'b00,2'b01,2'd2,2'b00,1'b0));

    do_reset("tbl");
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      arv = tbl[i].arv; addr[0] = tbl[i].a0; addr[1] = tbl[i].a1;
      len[0] = tbl[i].l0; len[1] = tbl[i].l1; arrdy_s = tbl[i].ars;
      rv_s = tbl[i].rv; rl_s = tbl[i].rl; rr_m = tbl[i].rr;
      #1;
      chk($sformatf("tbl row %0d", i), {1'b0, outs}, {1'b0, tbl[i].exp});
    end

    // ---------------- round-robin on two simultaneous requests
    do_reset("rr");
    @(negedge clk);
    arv = 2'b11; addr[0] = 32'h100; addr[1] = 32'h0001_0100;
    #1;
    chk("rr idle grant", 16'(grant), 16'h0);
    chk("rr idle arready", 16'({arready_m1, arready_m0}), 16'h0);
    @(negedge clk);
    arrdy_s = 2'b01;
    #1;
    chk("rr first grant", 16'(grant), 16'h1);
    chk("rr first route", 16'(route), 16'h0);
    chk("rr first arready", 16'({arready_m1, arready_m0}), 16'h1);
    @(negedge clk);
    arv = 2'b10; arrdy_s = '0; rv_s = 2'b01; rl_s = 2'b01; rr_m = 2'b11;
    #1;
    chk("rr first data", 16'({rvalid_m1, rvalid_m0}), 16'h1);
    chk("rr m1 held", 16'(arready_m1), 16'h0);
    @(negedge clk);
    arv = 2'b11; rv_s = '0; rl_s = '0; rr_m = '0;
    #1;
    chk("rr turnaround grant", 16'(grant), 16'h1);
    @(negedge clk);
    arrdy_s = 2'b10;
    #1;
    chk("rr second grant", 16'(grant), 16'h2);
    chk("rr second route", 16'(route), 16'h1);
    chk("rr second arvalid_s", 16'({arvalid_s1, arvalid_s0}), 16'h2);
    chk("rr second arready", 16'({arready_m1, arready_m0}), 16'h2);
    @(negedge clk);
    arv = 2'b01; arrdy_s = '0; rv_s = 2'b10; rl_s = 2'b10; rr_m = 2'b11;
    #1;
    chk("rr second data", 16'({rvalid_m1, rvalid_m0}), 16'h2);
    @(negedge clk);
    rv_s = '0; rl_s = '0; rr_m = '0;
    @(negedge clk);
    #1;
    chk("rr third grant", 16'(grant), 16'h1);

    // ---------------- S1 address stall for five cycles
    do_reset("stall");
    @(negedge clk);
    arv = 2'b10; addr[1] = 32'h0001_0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("stall arready_m1 c%0d", i), 16'(arready_m1), 16'h0);
      chk($sformatf("stall arvalid_s1 c%0d", i), 16'(arvalid_s1), 16'h1);
    end
    @(negedge clk);
    arrdy_s = 2'b10;
    #1;
    chk("stall handshake", 16'({arready_m1, arready_m0}), 16'h2);
    chk("stall route", 16'(route), 16'h1);
    @(negedge clk);
    arv = '0; rv_s = 2'b10; rl_s = 2'b10; rr_m = 2'b10;
    #1;
    chk("stall data arready", 16'(arready_m1), 16'h0);
    chk("stall data rvalid", 16'(rvalid_m1), 16'h1);
    @(negedge clk);
    clr();
    #1;
    chk("stall idle", {1'b0, outs}, {1'b0, mk(2'b00,2'b00,2'b00,2'b00,2'b10,2'd1,2'b00,1'b0)});

    // ---------------- reset in the middle of a data burst
    do_reset("mid");
    @(negedge clk);
    arv = 2'b01; addr[0] = 32'h20; len[0] = 4'd3;
    @(negedge clk);
    arrdy_s = 2'b01;
    @(negedge clk);
    arv = '0; arrdy_s = '0; rv_s = 2'b01; rr_m = 2'b01;
    @(negedge clk);
    #1;
    chk("mid beat2 rvalid", 16'(rvalid_m0), 16'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid async reset outs", {1'b0, outs}, 16'h0);
    arv = 2'b10; addr[1] = 32'h0001_0004; len[1] = 4'd0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid fresh idle", {1'b0, outs}, 16'h0);
    @(negedge clk);
    arrdy_s = 2'b10;
    #1;
    chk("mid m1 addr", {1'b0, outs}, {1'b0, mk(2'b10,2'b10,2'b00,2'b00,2'b10,2'd1,2'b00,1'b0)});
    @(negedge clk);
    arv = '0; arrdy_s = '0; rv_s = 2'b10; rl_s = 2'b10; rr_m = 2'b10;
    #1;
    chk("mid m1 data", {1'b0, outs}, {1'b0, mk(2'b00,2'b00,2'b10,2'b10,2'b10,2'd1,2'b00,1'b0)});
    @(negedge clk);
    clr();
    #1;
    chk("mid m1 done", {1'b0, outs}, {1'b0, mk(2'b00,2'b00,2'b00,2'b00,2'b10,2'd1,2'b00,1'b0)});

    // ---------------- randomized traffic against the transaction model
    do_reset("rand");
    busy = 0; in_addr = 0; owner = 0; tgt = 0; left = 0; prev = 1;
    m_grant = 2'b00; m_route = 2'd0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      arv     = 2'($urandom_range(0, 3));
      arrdy_s = 2'($urandom_range(0, 3));
      rv_s    = 2'($urandom_range(0, 3));
      rr_m    = 2'($urandom_range(0, 3));
      rl_s    = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      for (int m = 0; m < 2; m++) begin
        case ($urandom_range(0, 2))
          0:       addr[m] = {16'h0000, 16'($urandom)};
          1:       addr[m] = {16'h0001, 16'($urandom)};
          default: addr[m] = {16'($urandom_range(2, 65535)), 16'($urandom)};
        endcase
        len[m] = 4'($urandom_range(0, 3));
      end
      #1;
      e_arr = '0; e_avs = '0; e_rrs = '0; e_rvm = '0; e_rsp = 2'b00; e_lst = 1'b0;
      if (busy && in_addr) begin
        if (tgt < 2) begin
          e_avs[tgt]   = arv[owner];
          e_arr[owner] = arrdy_s[tgt];
        end else begin
          e_arr[owner] = 1'b1;
        end
      end else if (busy) begin
        if (tgt < 2) begin
          e_rvm[owner] = rv_s[tgt];
          e_rrs[tgt]   = rr_m[owner];
        end else begin
          e_rvm[owner] = 1'b1;
          e_rsp        = 2'b11;
          e_lst        = (left == 0);
        end
      end
      chk($sformatf("rand cycle %0d", i), {1'b0, outs},
          {1'b0, mk(e_arr, e_avs, e_rrs, e_rvm, m_grant, m_route, e_rsp, e_lst)});
      // advance the model by one clock
      if (!busy) begin
        if (arv != 2'b00) begin
          owner   = (arv == 2'b11) ? (1 - prev) : (arv[1] ? 1 : 0);
          prev    = owner;
          tgt     = region(addr[owner]);
          busy    = 1;
          in_addr = 1;
          m_grant = (owner == 1) ? 2'b10 : 2'b01;
          m_route = 2'(tgt);
        end
      end else if (in_addr) begin
        if (tgt == 2) begin
          left    = int'(len[owner]);
          in_addr = 0;
        end else if (arv[owner] && arrdy_s[tgt]) begin
          in_addr = 0;
        end
      end else if (tgt < 2) begin
        if (rv_s[tgt] && rr_m[owner] && rl_s[tgt]) busy = 0;
      end else if (rr_m[owner]) begin
        if (left == 0) busy = 0;
        else left = left - 1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
